// File: rtl/llc_mem_rsp_assembler.sv
// Collects word-wide memory beats into whole LLC lines and presents them on a valid/ready handshake.
// Optional ping-pong second line buffer enabled by defining LLC_MEM_RSP_SKID_EN.

`ifndef BITS_PER_WORD
`define BITS_PER_WORD 64
`endif
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif

module llc_mem_rsp_assembler #(
    parameter int WORD_W  = `BITS_PER_WORD,
    parameter int N_WORDS = `WORDS_PER_LINE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_beat_valid,
    output logic                      mem_beat_ready,
    input  logic [WORD_W-1:0]         mem_beat_data,
    input  logic                      mem_beat_last,
    output logic                      llc_mem_rsp_valid,
    input  logic                      llc_mem_rsp_ready,
    output logic [N_WORDS*WORD_W-1:0] llc_mem_rsp_line,
    output logic                      beat_err
);

    localparam int CNT_W  = $clog2(N_WORDS);
    localparam int LINE_W = N_WORDS * WORD_W;

    typedef logic [LINE_W-1:0] line_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             beatAccept;
    logic             finalBeat;
    logic             rspHandshake;

    assign beatAccept   = mem_beat_valid && mem_beat_ready;
    assign finalBeat    = (cnt_q == CNT_W'(N_WORDS - 1));
    assign rspHandshake = llc_mem_rsp_valid && llc_mem_rsp_ready;

    // The beat counter alone decides line boundaries; 'last' is only cross-checked.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (beatAccept) begin
            cnt_d = cnt_q + 1'b1;
            if (mem_beat_last != finalBeat) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign beat_err = err_q;

`ifdef LLC_MEM_RSP_SKID_EN

    line_t      lineBuf_q [2];
    logic [1:0] full_q, full_d;
    logic       wrSel_q, wrSel_d;
    logic       rdSel_q, rdSel_d;
    logic       ready_q, ready_d;

    // rdSel always points at the oldest complete line, so delivery follows completion order.
    always_comb begin
        full_d  = full_q;
        wrSel_d = wrSel_q;
        rdSel_d = rdSel_q;
        if (rspHandshake) begin
            full_d[rdSel_q] = 1'b0;
            rdSel_d         = ~rdSel_q;
        end
        if (beatAccept && finalBeat) begin
            full_d[wrSel_q] = 1'b1;
            wrSel_d         = ~wrSel_q;
        end
        ready_d = ~(full_d[0] & full_d[1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lineBuf_q[0] <= '0;
            lineBuf_q[1] <= '0;
            full_q       <= 2'b00;
            wrSel_q      <= 1'b0;
            rdSel_q      <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            if (beatAccept) begin
                lineBuf_q[wrSel_q][int'(cnt_q)*WORD_W +: WORD_W] <= mem_beat_data;
            end
            full_q  <= full_d;
            wrSel_q <= wrSel_d;
            rdSel_q <= rdSel_d;
            ready_q <= ready_d;
        end
    end

    assign mem_beat_ready    = ready_q;
    assign llc_mem_rsp_valid = full_q[rdSel_q];
    assign llc_mem_rsp_line  = lineBuf_q[rdSel_q];

`else

    typedef enum logic {FILL, FULL} state_e;

    state_e state_q;
    line_t  line_q;
    logic   ready_q;
    logic   valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            line_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (beatAccept) begin
                        line_q[int'(cnt_q)*WORD_W +: WORD_W] <= mem_beat_data;
                        if (finalBeat) begin
                            state_q <= FULL;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (llc_mem_rsp_ready) begin
                        state_q <= FILL;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_beat_ready    = ready_q;
    assign llc_mem_rsp_valid = valid_q;
    assign llc_mem_rsp_line  = line_q;

`endif

endmodule

// File: tb/tb_llc_mem_rsp_assembler.sv
// Self-checking bench for llc_mem_rsp_assembler with WORD_W=64, N_WORDS=2; covers base and
// LLC_MEM_RSP_SKID_EN builds using a queue-based line model plus literal expectations.

module tb_llc_mem_rsp_assembler;

    localparam int W  = 64;
    localparam int N  = 2;
    localparam int LW = N * W;
`ifdef LLC_MEM_RSP_SKID_EN
    localparam int CAP    = 2;
    localparam int PERIOD = 2;
`else
    localparam int CAP    = 1;
    localparam int PERIOD = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          memBeatValid = 1'b0;
    logic          memBeatReady;
    logic [W-1:0]  memBeatData = '0;
    logic          memBeatLast = 1'b0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [LW-1:0] rspLine;
    logic          beatErr;

    llc_mem_rsp_assembler #(.WORD_W(W), .N_WORDS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_beat_valid    (memBeatValid),
        .mem_beat_ready    (memBeatReady),
        .mem_beat_data     (memBeatData),
        .mem_beat_last     (memBeatLast),
        .llc_mem_rsp_valid (rspValid),
        .llc_mem_rsp_ready (rspReady),
        .llc_mem_rsp_line  (rspLine),
        .beat_err          (beatErr)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    logic [W-1:0]  partial  [$];
    logic [LW-1:0] expLines [$];
    logic          expErr = 1'b0;
    int            hsCycle  [$];
    logic          mReady, mValid;
    logic [LW-1:0] mLine;

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: a line exists once N accepted words accumulate; it stays pending until handshaken.
    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            partial.delete();
            expLines.delete();
            expErr = 1'b0;
            checkOutput("rst_ready", LW'(memBeatReady), LW'(1));
            checkOutput("rst_valid", LW'(rspValid), LW'(0));
            checkOutput("rst_line", rspLine, '0);
            checkOutput("rst_err", LW'(beatErr), LW'(0));
        end else begin
            mReady = (expLines.size() < CAP);
            mValid = (expLines.size() > 0);
            checkOutput("model_ready", LW'(memBeatReady), LW'(mReady));
            checkOutput("model_valid", LW'(rspValid), LW'(mValid));
            checkOutput("model_err", LW'(beatErr), LW'(expErr));
            if (mValid) begin
                checkOutput("model_line", rspLine, expLines[0]);
            end
            if (mValid && rspReady) begin
                void'(expLines.pop_front());
                hsCycle.push_back(cycle);
            end
            if (memBeatValid && mReady) begin
                if (memBeatLast != (partial.size() == N - 1)) begin
                    expErr = 1'b1;
                end
                partial.push_back(memBeatData);
                if (partial.size() == N) begin
                    mLine = '0;
                    for (int i = 0; i < N; i++) begin
                        mLine[i*W +: W] = partial[i];
                    end
                    expLines.push_back(mLine);
                    partial.delete();
                end
            end
        end
    end

    // Presents one beat and holds it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic l);
        bit ok;
        ok           = 1'b0;
        memBeatValid = 1'b1;
        memBeatData  = d;
        memBeatLast  = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (memBeatReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        memBeatValid = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL beat_accept_timeout: got no ready, expected ready within 50 cycles (data %h)", d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        rspReady = 1'b1;

        // Basic line
        applyStimulus(64'h1111, 1'b0);
        applyStimulus(64'h2222, 1'b1);
        checkOutput("basic_valid", LW'(rspValid), LW'(1));
        checkOutput("basic_line", rspLine, {64'h2222, 64'h1111});
        checkOutput("basic_err", LW'(beatErr), LW'(0));
        @(posedge clk);
        #1;

        // Backpressure
        rspReady = 1'b0;
        applyStimulus(64'h3333, 1'b0);
        applyStimulus(64'h4444, 1'b1);
        fork
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checkOutput("stall_valid", LW'(rspValid), LW'(1));
                    checkOutput("stall_line", rspLine, {64'h4444, 64'h3333});
`ifndef LLC_MEM_RSP_SKID_EN
                    checkOutput("stall_ready", LW'(memBeatReady), LW'(0));
`endif
                end
            end
`ifdef LLC_MEM_RSP_SKID_EN
            begin
                applyStimulus(64'h5555, 1'b0);
                applyStimulus(64'h6666, 1'b1);
            end
`endif
        join
        @(posedge clk);
        #1 rspReady = 1'b1;
        @(posedge clk);
        #1;
`ifdef LLC_MEM_RSP_SKID_EN
        checkOutput("skid_second_valid", LW'(rspValid), LW'(1));
        checkOutput("skid_second_line", rspLine, {64'h6666, 64'h5555});
        @(posedge clk);
        #1;
`else
        checkOutput("base_after_hs_ready", LW'(memBeatReady), LW'(1));
        checkOutput("base_after_hs_valid", LW'(rspValid), LW'(0));
`endif

        // Last-marker mismatch; error is sticky through later clean lines
        applyStimulus(64'h7777, 1'b1);
        checkOutput("mismatch_err_set", LW'(beatErr), LW'(1));
        applyStimulus(64'h8888, 1'b1);
        checkOutput("mismatch_line", rspLine, {64'h8888, 64'h7777});
        applyStimulus(64'h9999, 1'b0);
        applyStimulus(64'hAAAB, 1'b1);
        checkOutput("mismatch_err_sticky", LW'(beatErr), LW'(1));
        @(posedge clk);
        #1;

        // Back-to-back streaming of 8 lines
        hsCycle.delete();
        for (int ln = 0; ln < 8; ln++) begin
            for (int w = 0; w < N; w++) begin
                applyStimulus(64'(ln * 16 + w + 64'h100), (w == N - 1));
            end
        end
        repeat (3) @(negedge clk);
        checkOutput("stream_lines", LW'(hsCycle.size()), LW'(8));
        if (hsCycle.size() == 8) begin
            checkOutput("stream_span", LW'(hsCycle[7] - hsCycle[0]), LW'(7 * PERIOD));
        end
        @(posedge clk);
        #1;

        // Reset mid-line
        applyStimulus(64'hAAAA, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_ready", LW'(memBeatReady), LW'(1));
        checkOutput("async_rst_valid", LW'(rspValid), LW'(0));
        checkOutput("async_rst_line", rspLine, '0);
        checkOutput("async_rst_err", LW'(beatErr), LW'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(64'hB, 1'b0);
        applyStimulus(64'hC, 1'b1);
        checkOutput("post_rst_line", rspLine, {64'hC, 64'hB});
        @(posedge clk);
        #1;

`ifdef LLC_MEM_RSP_SKID_EN
        // Final beat of line 2 coincides with the handshake of line 1
        rspReady = 1'b0;
        applyStimulus(64'hD1, 1'b0);
        applyStimulus(64'hD2, 1'b1);
        applyStimulus(64'hE1, 1'b0);
        rspReady = 1'b1;
        applyStimulus(64'hE2, 1'b1);
        checkOutput("simul_valid", LW'(rspValid), LW'(1));
        checkOutput("simul_line", rspLine, {64'hE2, 64'hE1});
        @(posedge clk);
        #1;
        checkOutput("simul_no_dup", LW'(rspValid), LW'(0));
`endif

        repeat (3) @(negedge clk);
        checkOutput("idle_valid", LW'(rspValid), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
